// File: rtl/seg_scan_mux_pkg.sv
// Shared types and constants for the four-digit display scanner.
package seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int NIB_W      = 4;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

  typedef logic [1:0]       digit_idx_t;
  typedef logic [NIB_W-1:0] nibble_t;

  // Pick digit i out of a packed four-digit word (digit 0 is the low nibble).
  function automatic nibble_t nibble_at(input logic [NUM_DIGITS*NIB_W-1:0] word,
                                        input digit_idx_t i);
    return word[int'(i)*NIB_W +: NIB_W];
  endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Display-side bundle: value/enable/dp requests in, scanned digit drive out.
interface seg_scan_mux_if;
  import seg_pkg::*;

  logic [NUM_DIGITS*NIB_W-1:0] value;
  logic [NUM_DIGITS-1:0]       digit_en;
  logic [NUM_DIGITS-1:0]       dp_in;
  logic                        blank_lz;
  nibble_t                     hex_out;
  digit_idx_t                  digit_sel;
  logic [NUM_DIGITS-1:0]       an_L;
  logic                        dp_L;

  // Whoever supplies the number to show.
  modport master (
    output value, digit_en, dp_in, blank_lz,
    input  hex_out, digit_sel, an_L, dp_L
  );

  // The scanner itself.
  modport slave (
    input  value, digit_en, dp_in, blank_lz,
    output hex_out, digit_sel, an_L, dp_L
  );

endinterface

// File: rtl/seg_scan_mux_tick_gen.sv
// Slot prescaler: counts clk cycles within one digit slot and flags the last one.
module tick_gen import seg_pkg::*; #(
  parameter int TICK_COUNT = 100000,
  parameter int CNT_W      = $clog2(TICK_COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_COUNT - 1);

  assign tick = (cnt == LAST);

  // Free-running slot counter, wrapping after the last cycle of the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Four-digit common-anode scanner with frame-synchronous capture, per-digit
// enable, leading-zero blanking and an all-dark guard at the start of each slot.
module seg_scan_mux import seg_pkg::*; #(
  parameter int TICK_COUNT   = 100000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  seg_scan_mux_if.slave bus
);

  localparam int CNT_W = $clog2(TICK_COUNT);
  localparam digit_idx_t LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]            cnt;
  logic                        tick;
  digit_idx_t                  idx;
  logic [NUM_DIGITS*NIB_W-1:0] snap;
  logic [NUM_DIGITS-1:0]       snap_en;
  logic [NUM_DIGITS-1:0]       snap_dp;
  logic                        load_pending;
  logic                        frame_end;
  logic [NUM_DIGITS-1:0]       lz_sup;
  logic                        visible;
  logic [NUM_DIGITS-1:0]       one_hot;

  tick_gen #(
    .TICK_COUNT (TICK_COUNT),
    .CNT_W      (CNT_W)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .tick (tick)
  );

  assign frame_end = tick && (idx == LAST_DIGIT);

  // Digit index advances once per slot; the snapshot only refreshes at a frame
  // boundary (or right after reset) so a frame never mixes old and new digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx          <= '0;
      snap         <= '0;
      snap_en      <= '0;
      snap_dp      <= '0;
      load_pending <= 1'b1;
    end else begin
      load_pending <= 1'b0;
      if (tick) begin
        idx <= idx + digit_idx_t'(1);
      end
      if (frame_end || load_pending) begin
        snap    <= bus.value;
        snap_en <= bus.digit_en;
        snap_dp <= bus.dp_in;
      end
    end
  end

  // A digit is a leading zero when it and every digit above it are zero; the
  // rightmost digit is always kept so zero still reads as "0".
  always_comb begin
    lz_sup = '0;
    if (bus.blank_lz) begin
      lz_sup[1] = (snap[15:4]  == '0);
      lz_sup[2] = (snap[15:8]  == '0);
      lz_sup[3] = (snap[15:12] == '0);
    end
  end

  // Slot is lit only past the guard window, when enabled and not blanked.
  always_comb begin
    visible = (cnt >= CNT_W'(GUARD_CYCLES)) && snap_en[idx] && !lz_sup[idx];
    one_hot = NUM_DIGITS'(1) << idx;
  end

  // Registered drive stage; nibble and index track the scan even while dark.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.hex_out   <= '0;
      bus.digit_sel <= '0;
      bus.an_L      <= AN_OFF;
      bus.dp_L      <= 1'b1;
    end else begin
      bus.hex_out   <= nibble_at(snap, idx);
      bus.digit_sel <= idx;
      bus.an_L      <= visible ? ~one_hot : AN_OFF;
      bus.dp_L      <= visible ? ~snap_dp[idx] : 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux with TICK_COUNT=8, GUARD_CYCLES=2.
module tb_seg_scan_mux;
  import seg_pkg::*;

  localparam int TC    = 8;
  localparam int GC    = 2;
  localparam int FRAME = 4 * TC;

  typedef struct packed {
    logic [3:0] hex;
    logic [1:0] sel;
    logic [3:0] an;
    logic       dp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg_scan_mux_if bus ();

  seg_scan_mux #(
    .TICK_COUNT   (TC),
    .GUARD_CYCLES (GC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  int          k      = 0;
  logic [15:0] mVal   = '0;
  logic [3:0]  mEn    = '0;
  logic [3:0]  mDp    = '0;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at t=%0t k=%0d: got %0h, expected %0h",
               tag, $time, k, actual, expected);
    end
  endtask

  // Expected drive after the next edge, derived from elapsed cycles since reset.
  function automatic exp_t modelOut();
    exp_t e;
    int c;
    int d;
    int hi;
    logic vis;
    c  = k % TC;
    d  = (k / TC) % 4;
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      if (mVal[i*4 +: 4] != 4'h0) hi = i;
    end
    vis   = (c >= GC) && mEn[d] && !(bus.blank_lz && (d > hi));
    e.hex = mVal[d*4 +: 4];
    e.sel = 2'(d);
    e.an  = 4'hF;
    e.dp  = 1'b1;
    if (vis) begin
      e.an[d] = 1'b0;
      e.dp    = ~mDp[d];
    end
    return e;
  endfunction

  // One clock: push the expectation, let the edge happen, pop and compare.
  task automatic applyStimulus(input logic r);
    exp_t e;
    exp_t got;
    rst = r;
    if (r) begin
      e.hex = 4'h0;
      e.sel = 2'd0;
      e.an  = 4'hF;
      e.dp  = 1'b1;
      k     = 0;
      mVal  = '0;
      mEn   = '0;
      mDp   = '0;
    end else begin
      e = modelOut();
      if (k == 0 || (k % FRAME) == FRAME - 1) begin
        mVal = bus.value;
        mEn  = bus.digit_en;
        mDp  = bus.dp_in;
      end
      k++;
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    got = sbq.pop_front();
    checkOutput("hex_out",   32'(bus.hex_out),   32'(got.hex));
    checkOutput("digit_sel", 32'(bus.digit_sel), 32'(got.sel));
    checkOutput("an_L",      32'(bus.an_L),      32'(got.an));
    checkOutput("dp_L",      32'(bus.dp_L),      32'(got.dp));
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0);
  endtask

  // Advance until the scan is at a given position within the frame.
  task automatic waitPhase(input int phase);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if ((k % FRAME) == phase) break;
      applyStimulus(1'b0);
    end
  endtask

  initial begin
    bus.value    = 16'h1234;
    bus.digit_en = 4'b1111;
    bus.dp_in    = 4'b0000;
    bus.blank_lz = 1'b0;

    $display("[TB] reset held with value=1234");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1);
    runCycles(40);

    $display("[TB] full scan A5C3");
    bus.value = 16'hA5C3;
    runCycles(72);

    $display("[TB] tearing 1111 -> 2222 during digit 1");
    bus.value = 16'h1111;
    runCycles(40);
    waitPhase(TC + 2);
    bus.value = 16'h2222;
    runCycles(48);

    $display("[TB] leading-zero blanking");
    bus.blank_lz = 1'b1;
    bus.value    = 16'h0007;
    runCycles(40);
    bus.value = 16'h0000;
    runCycles(40);
    bus.value = 16'h0300;
    runCycles(40);
    bus.blank_lz = 1'b0;
    runCycles(36);

    $display("[TB] enables 1010 with dp 0010");
    bus.value    = 16'h89AB;
    bus.digit_en = 4'b1010;
    bus.dp_in    = 4'b0010;
    runCycles(72);

    $display("[TB] all digits disabled");
    bus.digit_en = 4'b0000;
    runCycles(40);

    $display("[TB] reset during slot 2 at cnt=5");
    bus.digit_en = 4'b1111;
    bus.dp_in    = 4'b0101;
    bus.value    = 16'h4321;
    runCycles(34);
    waitPhase(2 * TC + 5);
    applyStimulus(1'b1);
    runCycles(40);

    checkOutput("sb_empty", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
